// File: rtl/bus_pkg.sv
// Shared types and helpers for the bit-serial system bus.
//   master_state_t : master port frame states
//   MODE_READ/WRITE: values carried on the bus mode wire
//   cnt_width()    : bit counter width able to hold max(a, b)
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        WDATA,
        RWAIT,
        RDATA,
        DONE
    } master_state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in, serial-out shifter, MSB first; zeros shift in from the LSB end.
//   clk, rstn : clock, synchronous active-low reset
//   load, din : parallel load (has priority over shift)
//   shift     : advance one bit
//   msb       : current head bit
module piso_shifter
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             shift,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/master_port.sv
// Bit-serial bus master: takes parallel client requests, serialises address
// then write data MSB first on wr_bus, and deserialises read data from rd_bus.
//   Client side : req_valid/req_ready/req_write/req_addr/req_wdata in,
//                 resp_valid/resp_err/resp_rdata out
//   Bus side    : mode/master_valid/wr_bus/master_ready out,
//                 rd_bus/slave_ready/slave_valid in
// Optional macro MASTER_TIMEOUT_EN: bounds REQ/RWAIT waits to TIMEOUT_CYCLES.
module master_port
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mode,
    output logic                  master_valid,
    output logic                  wr_bus,
    output logic                  master_ready,
    input  logic                  rd_bus,
    input  logic                  slave_ready,
    input  logic                  slave_valid
);

    localparam int unsigned CNT_W = cnt_width(ADDR_WIDTH, DATA_WIDTH);

    master_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             addr_last;
    logic             data_last;
    logic             addr_shift;
    logic             data_shift;
    logic             rd_shift;
    logic             addr_msb;
    logic             data_msb;
    logic             timeout;
    logic             finish;
    logic             finish_err;

    assign accept     = req_valid && req_ready;
    assign addr_last  = (cnt == CNT_W'(ADDR_WIDTH - 1));
    assign data_last  = (cnt == CNT_W'(DATA_WIDTH - 1));
    assign addr_shift = slave_ready && ((state == REQ) || (state == ADDR));
    assign data_shift = slave_ready && ((state == WDATA) ||
                        ((state == ADDR) && addr_last && (mode == MODE_WRITE)));
    assign rd_shift   = slave_valid && ((state == RWAIT) || (state == RDATA));

    // Address MSB goes straight to wr_bus on accept, so the shifter holds the
    // remaining bits and its head is always the next bit to present.
    piso_shifter #(.WIDTH(ADDR_WIDTH)) u_addr_sh (
        .clk   (clk),
        .rstn  (rstn),
        .load  (accept),
        .din   ({req_addr[ADDR_WIDTH-2:0], 1'b0}),
        .shift (addr_shift),
        .msb   (addr_msb)
    );

    // Data shifter advances on the last address bit so its head leads wr_bus.
    piso_shifter #(.WIDTH(DATA_WIDTH)) u_data_sh (
        .clk   (clk),
        .rstn  (rstn),
        .load  (accept),
        .din   (req_wdata),
        .shift (data_shift),
        .msb   (data_msb)
    );

`ifdef MASTER_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt;

    // Consecutive cycles spent waiting for the handshake in REQ or RWAIT.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wait_cnt <= '0;
        end else if (((state == REQ) && !slave_ready) || ((state == RWAIT) && !slave_valid)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = |TIMEOUT_CYCLES;
    assign timeout               = 1'b0;
`endif

    // Frame termination: normal completion, slave drop, or wait timeout.
    always_comb begin
        finish     = 1'b0;
        finish_err = 1'b0;
        case (state)
            REQ:     if (!slave_ready && timeout) begin finish = 1'b1; finish_err = 1'b1; end
            ADDR:    if (!slave_ready) begin finish = 1'b1; finish_err = 1'b1; end
            WDATA:   if (!slave_ready) begin finish = 1'b1; finish_err = 1'b1; end
                     else if (data_last) finish = 1'b1;
            RWAIT:   if (!slave_valid && timeout) begin finish = 1'b1; finish_err = 1'b1; end
            RDATA:   if (slave_valid && data_last) finish = 1'b1;
            default: ;
        endcase
    end

    // Frame sequencer with registered bus and client outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
            mode         <= MODE_READ;
            master_valid <= 1'b0;
            wr_bus       <= 1'b0;
            master_ready <= 1'b0;
        end else begin
            if (rd_shift) begin
                resp_rdata <= {resp_rdata[DATA_WIDTH-2:0], rd_bus};
            end
            if (finish) begin
                state        <= DONE;
                cnt          <= '0;
                resp_valid   <= 1'b1;
                resp_err     <= finish_err;
                mode         <= MODE_READ;
                master_valid <= 1'b0;
                wr_bus       <= 1'b0;
                master_ready <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        state        <= REQ;
                        cnt          <= '0;
                        req_ready    <= 1'b0;
                        mode         <= req_write;
                        master_valid <= 1'b1;
                        wr_bus       <= req_addr[ADDR_WIDTH-1];
                    end
                    REQ: if (slave_ready) begin
                        state  <= ADDR;
                        cnt    <= CNT_W'(1);
                        wr_bus <= addr_msb;
                    end
                    ADDR: if (addr_last) begin
                        cnt <= '0;
                        if (mode == MODE_WRITE) begin
                            state  <= WDATA;
                            wr_bus <= data_msb;
                        end else begin
                            state        <= RWAIT;
                            master_valid <= 1'b0;
                            wr_bus       <= 1'b0;
                            master_ready <= 1'b1;
                        end
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                        wr_bus <= addr_msb;
                    end
                    WDATA: begin
                        cnt    <= cnt + CNT_W'(1);
                        wr_bus <= data_msb;
                    end
                    RWAIT: if (slave_valid) begin
                        state <= RDATA;
                        cnt   <= CNT_W'(1);
                    end
                    RDATA: if (slave_valid) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    DONE: begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/master_port.md
Name: master_port

Overview:
Bit-serial bus master: the initiator end of the single-wire system bus whose responder is the serial slave port.
- Accepts parallel read/write requests from a local client.
- Serialises the address, then the write data, MSB first on wr_bus, together with the mode/valid handshake.
- For reads, deserialises the response from rd_bus.
- Sits between a CPU/testbench-side requester and the bus interconnect.

Parameters:
ADDR_WIDTH, 16, address bits per frame.
DATA_WIDTH, 8, data bits per frame.
TIMEOUT_CYCLES, 64, wait-cycle limit; used only when MASTER_TIMEOUT_EN is defined.

Ports:
clk  input  1  clock; all logic on rising edge.
rstn  input  1  reset, synchronous, active-low.
req_valid  input  1  client request present.
req_ready  output  1  master can accept request (high only in IDLE).
req_write  input  1  1=write, 0=read.
req_addr  input  ADDR_WIDTH  request address.
req_wdata  input  DATA_WIDTH  write data.
resp_valid  output  1  one-cycle pulse: transaction finished.
resp_err  output  1  qualifies resp_valid: frame aborted.
resp_rdata  output  DATA_WIDTH  read data; held until next accepted request.
mode  output  1  bus mode, latched req_write, stable for whole frame.
master_valid  output  1  frame active / bit on wr_bus valid.
wr_bus  output  1  serial address/data, MSB first.
master_ready  output  1  master accepting read bits.
rd_bus  input  1  serial read data, MSB first.
slave_ready  input  1  slave accepting address/data bits.
slave_valid  input  1  slave driving a valid read bit.

Behaviour:
- Reset (rstn=0 at edge): state IDLE; counter, shift registers and every output are 0; req_ready is 1 after reset.
- Reset mid-frame abandons the frame with no resp_valid. master_valid is low from the next cycle.
- Accept: req_valid && req_ready latches addr, wdata and write; next state REQ.
- Write-bit transfer: a cycle with master_valid && slave_ready moves one bit; the shifter then advances.
- Read-bit transfer: a cycle with slave_valid && master_ready moves one bit.
- States:
  - IDLE: req_ready=1; all bus outputs 0.
  - REQ: master_valid=1; wr_bus=addr[MSB]. Waits indefinitely for slave_ready. A transfer here counts as address bit 0 (counter=1), then go to ADDR.
  - ADDR: master_valid=1; wr_bus=next address bit. After ADDR_WIDTH bits, go to WDATA if mode=1, else RWAIT.
  - WDATA: master_valid=1; wr_bus=data MSB first. After DATA_WIDTH bits, go to DONE.
  - RWAIT: master_valid=0; master_ready=1; wait for slave_valid. A transfer here is read bit 0; go to RDATA.
  - RDATA: master_ready=1; shift rd_bus into resp_rdata LSB end on each transfer. After DATA_WIDTH bits, go to DONE. Cycles with slave_valid=0 are stalls, not errors.
  - DONE: resp_valid=1 for exactly one cycle, then IDLE.
- Abort: slave_ready=0 in ADDR or WDATA means the slave dropped the frame. Go to DONE with resp_err=1; master_valid drops next cycle.
- Counter width: $clog2(max(ADDR_WIDTH,DATA_WIDTH)+1). Reset to 0 on each phase entry; never wraps inside a frame.
- mode is driven as 0 outside REQ/ADDR/WDATA/RWAIT/RDATA.
- Back-to-back: the earliest next accept is the cycle after DONE, because IDLE lasts at least one cycle.
- resp_rdata updates only in RDATA. Writes and aborts leave it unchanged.

Optional Feature:
MASTER_TIMEOUT_EN.
- Defined: a wait counter runs in REQ and RWAIT and resets on state entry. After TIMEOUT_CYCLES consecutive cycles without the awaited handshake, go to DONE with resp_err=1.
- Undefined: no counter, unbounded waits, TIMEOUT_CYCLES unused.

Decomposition:
- Package bus_pkg:
  - state enum master_state_t {IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, DONE}
  - MODE_READ=1'b0, MODE_WRITE=1'b1
  - width helper function for counter sizing
- One natural sub-module, piso_shifter: parallel-load, shift-on-enable, MSB-out. It is instantiated for the address and for the write data.

Test Plan:
- Write addr=0x0025, wdata=0xA5, slave_ready always 1 -> wr_bus shows 0000000000100101 then 10100101 over 24 cycles; mode=1 throughout; one resp_valid with resp_err=0.
- Read addr=0x0003; slave model drives 0x3C after 3 idle cycles -> master_ready high through RWAIT/RDATA; resp_rdata=0x3C; resp_valid pulse with resp_err=0.
- Read with slave_valid gaps after bits 2 and 5 -> stalls tolerated; resp_rdata still equals the sent byte (e.g. 0x81).
- slave_ready drops after 5 address bits -> resp_valid=1 with resp_err=1 next cycle; master_valid=0 after; resp_rdata unchanged.
- rstn=0 during WDATA bit 3 -> all outputs 0 next cycle; no resp_valid; a new write then completes normally.
- MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave_ready stuck 0 -> resp_err=1 pulse 16 cycles after REQ entry. Same stimulus without the macro -> stays in REQ.
